// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU memory stage
// and the DMA loader port.
package dmem_arb_pkg;

  localparam int unsigned DEF_BURST_MAX = 16;
  localparam int unsigned LEN_W         = $clog2(DEF_BURST_MAX) + 1;
  localparam int unsigned WORD_BYTES    = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BURST
  } arb_state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// DMA burst sequencer: latches base address and clamped beat count on load, then walks
// word addresses and flags the final beat.
module burst_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       advance,
  input  logic [ADDR_WIDTH-1:0]      base,
  input  logic [$clog2(BURST_MAX):0] len,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic                       last,
  output logic [$clog2(BURST_MAX):0] idx
);

  localparam int unsigned LenW = $clog2(BURST_MAX) + 1;

  logic [ADDR_WIDTH-1:0] baseQ;
  logic [LenW-1:0]       lenQ;
  logic [LenW-1:0]       idxQ;
  logic [LenW-1:0]       lenEff;

  // Zero-length requests still move one word; oversize requests clamp to the maximum.
  always_comb begin
    lenEff = len;
    if (len == '0) begin
      lenEff = LenW'(1);
    end else if (len > LenW'(BURST_MAX)) begin
      lenEff = LenW'(BURST_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baseQ <= '0;
      lenQ  <= '0;
      idxQ  <= '0;
    end else if (load) begin
      baseQ <= base;
      lenQ  <= lenEff;
      idxQ  <= '0;
    end else if (advance) begin
      idxQ <= last ? '0 : idxQ + LenW'(1);
    end
  end

  assign last = (idxQ == lenQ - LenW'(1));
  assign addr = baseQ + ADDR_WIDTH'(idxQ) * ADDR_WIDTH'(WORD_BYTES);
  assign idx  = idxQ;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates datamem between the CPU memory stage and a DMA burst port.
// Optional DMEM_ARB_STARVE_EN forces a DMA grant after STARVE_LIMIT blocked cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BURST_MAX    = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0]      cpu_wdata,
  output logic [DATA_WIDTH-1:0]      cpu_rdata,
  output logic                       cpu_stall,
  input  logic                       dma_req,
  input  logic                       dma_we,
  input  logic [ADDR_WIDTH-1:0]      dma_addr,
  input  logic [$clog2(BURST_MAX):0] dma_len,
  output logic                       dma_ack,
  input  logic [DATA_WIDTH-1:0]      dma_wdata,
  output logic                       dma_beat,
  output logic [DATA_WIDTH-1:0]      dma_rdata,
  output logic                       dma_done,
  output logic                       dma_busy,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wd,
  input  logic [DATA_WIDTH-1:0]      mem_rd
);

  if (BURST_MAX < 2 || (BURST_MAX & (BURST_MAX - 1)) != 0 || STARVE_LIMIT < 1) begin : gParamCheck
    $error("dmem_arbiter: BURST_MAX must be a power of two >= 2, STARVE_LIMIT >= 1");
  end

  arb_state_t stateQ, stateD;
  logic       weQ;
  logic       load;
  logic       advance;
  logic       starveGrant;

  logic [ADDR_WIDTH-1:0]      burstAddr;
  logic                       burstLast;
  logic [$clog2(BURST_MAX):0] beatIdx;

  burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) uAddrGen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .base    (dma_addr),
    .len     (dma_len),
    .addr    (burstAddr),
    .last    (burstLast),
    .idx     (beatIdx)
  );

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

  logic [WaitW-1:0] waitQ, waitD;

  assign starveGrant = (stateQ == IDLE) && dma_req && (waitQ == WaitW'(STARVE_LIMIT));

  always_comb begin
    waitD = waitQ;
    if (!dma_req || load) begin
      waitD = '0;
    end else if (stateQ == IDLE && cpu_req && waitQ != WaitW'(STARVE_LIMIT)) begin
      waitD = waitQ + WaitW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitQ <= '0;
    end else begin
      waitQ <= waitD;
    end
  end
`else
  assign starveGrant = 1'b0;
`endif

  always_comb begin
    stateD    = stateQ;
    load      = 1'b0;
    advance   = 1'b0;
    dma_ack   = 1'b0;
    dma_beat  = 1'b0;
    dma_done  = 1'b0;
    dma_busy  = 1'b0;
    cpu_stall = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wd    = cpu_wdata;
    unique case (stateQ)
      IDLE: begin
        if (cpu_req && !starveGrant) begin
          mem_we = cpu_we;
        end else if (dma_req) begin
          // Only a starvation grant can reach here with cpu_req high.
          dma_ack   = 1'b1;
          load      = 1'b1;
          cpu_stall = cpu_req;
          stateD    = GRANT;
        end
      end
      GRANT: begin
        dma_busy  = 1'b1;
        cpu_stall = cpu_req;
        stateD    = BURST;
      end
      BURST: begin
        dma_busy  = 1'b1;
        dma_beat  = 1'b1;
        cpu_stall = cpu_req;
        advance   = 1'b1;
        mem_addr  = burstAddr;
        mem_we    = weQ;
        mem_wd    = dma_wdata;
        if (burstLast) begin
          dma_done = 1'b1;
          stateD   = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      weQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (load) begin
        weQ <= dma_we;
      end
    end
  end

  assign cpu_rdata = mem_rd;
  assign dma_rdata = mem_rd;

  // Every burst starts from beat zero once the dead cycle is over.
  assert property (@(posedge clk) disable iff (rst) (stateQ == GRANT) |-> (beatIdx == '0));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: CPU vector table, directed DMA corner cases and
// randomized traffic against a word-level memory/burst reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_stall;
  logic             dma_req, dma_we;
  logic [31:0]      dma_addr;
  logic [LEN_W-1:0] dma_len;
  logic             dma_ack;
  logic [31:0]      dma_wdata, dma_rdata;
  logic             dma_beat, dma_done, dma_busy;
  logic             mem_we;
  logic [31:0]      mem_addr, mem_wd, mem_rd;

  int checks   = 0;
  int failures = 0;

  // 4 KB aliased data memory seen by the DUT, and the bench's expected image of it.
  logic [31:0] memArr [1024];
  logic [31:0] refMem [1024];
  logic        memClr;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .BURST_MAX    (16),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_ack   (dma_ack),
    .dma_wdata (dma_wdata),
    .dma_beat  (dma_beat),
    .dma_rdata (dma_rdata),
    .dma_done  (dma_done),
    .dma_busy  (dma_busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  assign mem_rd = memArr[mem_addr[11:2]];

  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= '0;
    end else if (mem_we) begin
      memArr[mem_addr[11:2]] <= mem_wd;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } cpu_vec_t;

  cpu_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int effLen(input logic [LEN_W-1:0] len);
    if (len == 0) return 1;
    if (len > 16) return 16;
    return int'(len);
  endfunction

  task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(negedge clk);
    chk("cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("cpu_mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("cpu_mem_addr", mem_addr, addr);
    if (we) refMem[addr[11:2]] = wd;
    else chk("cpu_rdata", cpu_rdata, refMem[addr[11:2]]);
    nextCycle();
    cpu_req = 1'b0;
  endtask

  task automatic dmaBurst(input logic we, input logic [31:0] base, input logic [LEN_W-1:0] len,
                          input logic [31:0] seed, input logic hold, input logic [31:0] holdAddr);
    int          n;
    logic [31:0] a;
    n        = effLen(len);
    cpu_req  = 1'b0;
    dma_req  = 1'b1;
    dma_we   = we;
    dma_addr = base;
    dma_len  = len;
    @(negedge clk);
    chk("dma_ack", {31'd0, dma_ack}, 32'd1);
    chk("ack_mem_we", {31'd0, mem_we}, 32'd0);
    nextCycle();
    // Scramble the request fields: the burst must use what was latched at grant.
    dma_req  = 1'b0;
    dma_we   = ~we;
    dma_addr = $urandom;
    dma_len  = LEN_W'($urandom);
    cpu_req  = hold;
    cpu_we   = 1'b0;
    cpu_addr = holdAddr;
    @(negedge clk);
    chk("grant_busy", {31'd0, dma_busy}, 32'd1);
    chk("grant_beat", {31'd0, dma_beat}, 32'd0);
    chk("grant_mem_we", {31'd0, mem_we}, 32'd0);
    chk("grant_stall", {31'd0, cpu_stall}, {31'd0, hold});
    nextCycle();
    for (int i = 0; i < n; i++) begin
      a         = base + 32'(4 * i);
      dma_wdata = seed + 32'(i);
      @(negedge clk);
      chk("beat_flag", {31'd0, dma_beat}, 32'd1);
      chk("beat_addr", mem_addr, a);
      chk("beat_we", {31'd0, mem_we}, {31'd0, we});
      chk("beat_done", {31'd0, dma_done}, {31'd0, i == n - 1});
      chk("beat_stall", {31'd0, cpu_stall}, {31'd0, hold});
      if (we) begin
        chk("beat_wd", mem_wd, seed + 32'(i));
        refMem[a[11:2]] = seed + 32'(i);
      end else begin
        chk("beat_rdata", dma_rdata, refMem[a[11:2]]);
      end
      nextCycle();
    end
    @(negedge clk);
    chk("post_busy", {31'd0, dma_busy}, 32'd0);
    if (hold) begin
      chk("post_stall", {31'd0, cpu_stall}, 32'd0);
      chk("post_cpu_rdata", cpu_rdata, refMem[holdAddr[11:2]]);
    end
    nextCycle();
    cpu_req = 1'b0;
  endtask

  initial begin
    int ackAt;
    int drained;
    rst = 1'b1;
    memClr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = '0;

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h20, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 32'h10, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 32'h20, 32'h0, 32'h12345678};
    vecs[5] = '{1'b0, 32'h10, 32'h0, 32'hCAFEF00D};

    @(negedge clk);
    chk("reset_outputs", {26'd0, dma_ack, dma_beat, dma_done, dma_busy, cpu_stall, mem_we}, 32'd0);
    nextCycle();
    rst = 1'b0;
    memClr = 1'b0;

    for (int v = 0; v < 6; v++) begin
      cpu_req = 1'b1; cpu_we = vecs[v].we; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      @(negedge clk);
      chk("vec_stall", {31'd0, cpu_stall}, 32'd0);
      chk("vec_mem_we", {31'd0, mem_we}, {31'd0, vecs[v].we});
      chk("vec_mem_addr", mem_addr, vecs[v].addr);
      if (vecs[v].we) begin
        chk("vec_mem_wd", mem_wd, vecs[v].wdata);
        refMem[vecs[v].addr[11:2]] = vecs[v].wdata;
      end else begin
        chk("vec_rdata", cpu_rdata, vecs[v].expRdata);
      end
      nextCycle();
    end
    cpu_req = 1'b0;

    dmaBurst(1'b1, 32'h100, LEN_W'(4), 32'd1, 1'b0, 32'h0);
    cpuOp(1'b0, 32'h10C, 32'h0);
    chk("load_10c", refMem[32'h10C >> 2], 32'd4);
    dmaBurst(1'b0, 32'h100, LEN_W'(3), 32'd0, 1'b1, 32'h104);
    dmaBurst(1'b1, 32'h200, LEN_W'(0), 32'h55, 1'b0, 32'h0);
    dmaBurst(1'b1, 32'h300, LEN_W'(31), 32'h1000, 1'b0, 32'h0);
    dmaBurst(1'b0, 32'h300, LEN_W'(16), 32'h0, 1'b1, 32'h33C);
    dmaBurst(1'b1, 32'hFFFF_FFFC, LEN_W'(2), 32'h77, 1'b0, 32'h0);
    cpuOp(1'b0, 32'h0, 32'h0);

    // Reset lands on the third beat of an 8-beat write burst.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h400; dma_len = LEN_W'(8);
    @(negedge clk);
    chk("rst_burst_ack", {31'd0, dma_ack}, 32'd1);
    nextCycle();
    dma_req = 1'b0;
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      dma_wdata = 32'hA0 + 32'(i);
      refMem[(32'h400 >> 2) + i] = dma_wdata;
      nextCycle();
    end
    dma_wdata = 32'hA2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {26'd0, dma_ack, dma_beat, dma_done, dma_busy, cpu_stall, mem_we}, 32'd0);
    @(negedge clk);
    chk("rst_mid_done", {31'd0, dma_done}, 32'd0);
    nextCycle();
    rst = 1'b0;
    cpuOp(1'b0, 32'h408, 32'h0);
    cpuOp(1'b0, 32'h404, 32'h0);
    chk("rst_no_extra_write", memArr[32'h40C >> 2], refMem[32'h40C >> 2]);

    // CPU and DMA both held high.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = LEN_W'(1);
    ackAt = 0;
    for (int c = 1; c <= 20 && ackAt == 0; c++) begin
      @(negedge clk);
      if (dma_ack) begin
        ackAt = c;
        chk("starve_ack_stall", {31'd0, cpu_stall}, 32'd1);
      end else begin
        chk("contend_stall", {31'd0, cpu_stall}, 32'd0);
      end
      nextCycle();
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve_ack_cycle", 32'(ackAt), 32'd9);
`else
    chk("no_starve_ack", 32'(ackAt), 32'd0);
`endif
    dma_req = 1'b0;
    drained = 0;
    for (int c = 0; c < 10 && drained == 0; c++) begin
      @(negedge clk);
      if (!dma_busy) drained = 1;
      nextCycle();
    end
    chk("drain_timeout", 32'(drained), 32'd1);
    cpu_req = 1'b0;
    nextCycle();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: cpuOp(1'b1, {20'd0, 10'($urandom), 2'b00}, $urandom);
        1: cpuOp(1'b0, {20'd0, 10'($urandom), 2'b00}, 32'h0);
        default: dmaBurst(1'($urandom), {20'd0, 10'($urandom), 2'b00}, LEN_W'($urandom),
                          $urandom, 1'($urandom), {20'd0, 10'($urandom), 2'b00});
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (`datamem`) between two requesters: the pipeline's memory stage (CPU port) and an external loader/DMA port.
- Sits between the EM pipeline register outputs and `datamem`.
- Sequences multi-beat DMA bursts with internally generated addresses.
- Freezes the pipeline through `cpu_stall` while the memory is owned by DMA.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 32, width of byte addresses.
- BURST_MAX, 16, maximum beats per DMA burst (power of two, ≥2).
- STARVE_LIMIT, 8, cycles a DMA request may wait behind CPU traffic before forced grant (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  memory-stage access this cycle (MemWriteM or load).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address (ALUResultM).
- cpu_wdata  in  DATA_WIDTH  store data (WriteDataM).
- cpu_rdata  out  DATA_WIDTH  load data (ReadDataM).
- cpu_stall  out  1  freeze F/D/E/M stages and bubble W.
- dma_req  in  1  burst request, level, held until dma_ack.
- dma_we  in  1  burst direction; sampled with dma_req at grant.
- dma_addr  in  ADDR_WIDTH  burst base byte address; sampled at grant.
- dma_len  in  $clog2(BURST_MAX)+1  requested beat count; sampled at grant.
- dma_ack  out  1  one-cycle pulse: burst accepted.
- dma_wdata  in  DATA_WIDTH  write beat data, valid every burst cycle.
- dma_beat  out  1  a beat executes this cycle (write consumed / read valid).
- dma_rdata  out  DATA_WIDTH  read beat data, qualified by dma_beat.
- dma_done  out  1  pulse on the last beat.
- dma_busy  out  1  arbiter in burst state.
- mem_we  out  1  datamem write enable.
- mem_addr  out  ADDR_WIDTH  datamem address.
- mem_wd  out  DATA_WIDTH  datamem write data.
- mem_rd  in  DATA_WIDTH  datamem combinational read data.

Behaviour:
- **Reset:**
  - State IDLE; beat counter, latched base/len/we and wait counter all 0.
  - Outputs: dma_ack, dma_beat, dma_done, dma_busy, cpu_stall and mem_we all 0.
  - mem_addr, mem_wd, dma_rdata and cpu_rdata are combinational data paths with no reset value.
  - Reset mid-burst aborts the burst: no dma_done, remaining beats discarded.
- **States:** IDLE, GRANT, BURST.
- **IDLE:**
  - If cpu_req: mem_* follow cpu_*, cpu_rdata = mem_rd, cpu_stall = 0. Zero latency; datamem writes at the clock edge.
  - Else if dma_req: dma_ack = 1, latch dma_addr/dma_len/dma_we, go to GRANT. mem_we = 0.
  - cpu_req has strict priority over dma_req.
- **GRANT:**
  - One dead cycle; memory is idle and mem_we = 0.
  - cpu_stall = cpu_req, dma_busy = 1; go to BURST with beat index i = 0.
- **BURST:**
  - mem_addr = base + 4·i, modulo 2^ADDR_WIDTH (wraps silently).
  - Write burst: mem_we = 1, mem_wd = dma_wdata.
  - Read burst: mem_we = 0, dma_rdata = mem_rd.
  - dma_beat = 1 and dma_busy = 1 on every cycle of the burst; cpu_stall = cpu_req.
  - i increments each cycle. On i == len_eff−1: dma_done = 1, next state IDLE.
  - The stalled CPU access is served in the following IDLE cycle.
- **Length rule:**
  - len_eff = 1 if dma_len == 0.
  - len_eff = BURST_MAX if dma_len > BURST_MAX.
  - Otherwise len_eff = dma_len.
- **Simultaneous events:**
  - A dma_req that is still high in the IDLE cycle after dma_done begins a new burst only if cpu_req is low.
  - cpu_rdata is don't-care while cpu_stall = 1.
  - The CPU port never writes while DMA owns memory.
- **Burst latency:** a burst of N beats occupies N+1 cycles after dma_ack (GRANT + N beats).

Optional Feature:
- Macro: DMEM_ARB_STARVE_EN.
- **Defined:**
  - The wait counter increments each IDLE cycle in which dma_req && cpu_req.
  - When it equals STARVE_LIMIT, the next IDLE cycle grants DMA even with cpu_req high. That cycle has dma_ack = 1 and cpu_stall = 1.
  - The counter clears on every grant and whenever dma_req is low.
- **Undefined:**
  - No counter; strict CPU priority (DMA can starve indefinitely).
  - Behaviour is otherwise identical.

Decomposition:
- Package `dmem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT, BURST}.
  - localparam LEN_W = $clog2(BURST_MAX)+1.
  - localparam WORD_BYTES = 4.
- One sub-module `burst_addr_gen`: latches base/len_eff on a load strobe and outputs the current address, the last-beat flag and the beat index.
- Arbitration FSM and muxing stay in the top module.

Test Plan:
- CPU store 0x10←0xDEADBEEF then load 0x10, no DMA → cpu_stall = 0 throughout; cpu_rdata = 0xDEADBEEF in the load cycle.
- DMA write burst base 0x100, len 4, data 1..4, CPU idle → dma_ack cycle 0, GRANT cycle 1, beats cycles 2–5 to 0x100/104/108/10C; dma_done in cycle 5. A subsequent CPU load of 0x10C returns 4.
- DMA read burst len 3 while cpu_req held high from GRANT → cpu_stall = 1 for 4 cycles. The CPU load completes in the IDLE cycle after dma_done with correct data.
- Boundaries:
  - dma_len = 0 → exactly 1 beat with dma_done.
  - dma_len = 31 with BURST_MAX = 16 → 16 beats.
  - base 0xFFFFFFFC, len 2 → second address 0x00000000.
- Reset asserted on beat 2 of a len-8 burst → all outputs 0 immediately; no dma_done; the next cpu_req is served unstalled.
- With DMEM_ARB_STARVE_EN and STARVE_LIMIT = 8: cpu_req and dma_req held high → dma_ack on the 9th IDLE cycle. Without the macro: dma_ack never asserts while cpu_req is held high.
